logger_fifo_arb: RTL and testbench

//  Round-robin, record-granular arbiter that shares the logger byte FIFO among N producers.

---
 rtl/logger_fifo_arb.sv | 109 ++++++++++
 tb/tb_logger_fifo_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logger_fifo_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logger_fifo_arb : round-robin, record-granular arbiter feeding one byte FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module logger_fifo_arb #(
  parameter int N_SRC         = 2,
  parameter int MAX_REC_BYTES = 56,
  parameter int CNT_W         = 16,
  parameter int GW            = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   s_valid,
  input  logic [8*N_SRC-1:0] s_data,
  input  logic [N_SRC-1:0]   s_last,
  output logic [N_SRC-1:0]   s_ready,
  output logic               fifo_wr_en,
  output logic [7:0]         fifo_din,
  input  logic               fifo_full,
  input  logic               fifo_prog_full,
  input  logic               fifo_wr_rst_busy,
  output logic               busy,
  output logic [GW-1:0]      grant_idx,
  output logic [CNT_W-1:0]   rec_count,
  output logic               err_overlen
);

  localparam int BW = $clog2(MAX_REC_BYTES + 2);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_REC_BYTES);
  localparam logic [BW-1:0] BEAT_SAT = BW'(MAX_REC_BYTES + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   beat_cnt;
  logic [GW-1:0]   winner;
  logic [GW:0]     scan_sum;
  logic            found;
  logic            arb_go;
  logic            can_wr;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  assign can_wr    = !fifo_full && !fifo_wr_rst_busy;
  assign arb_go    = (|s_valid) && !fifo_prog_full && !fifo_wr_rst_busy;
  assign sel_valid = s_valid[grant_idx];
  assign sel_last  = s_last[grant_idx];
  assign sel_data  = s_data[{grant_idx, 3'b000} +: 8];
  assign busy      = (state == XFER);

  // Scan starts one past the last grant, so the previous owner goes last.
  always_comb begin
    winner   = grant_idx;
    found    = 1'b0;
    scan_sum = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      scan_sum = {1'b0, grant_idx} + (GW+1)'(k);
      if (scan_sum >= (GW+1)'(N_SRC)) scan_sum = scan_sum - (GW+1)'(N_SRC);
      if (!found && s_valid[scan_sum[GW-1:0]]) begin
        found  = 1'b1;
        winner = scan_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    s_ready    = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = 8'h00;
    case (state)
      IDLE: begin
        if (arb_go) state_nx = XFER;
      end
      XFER: begin
        s_ready[grant_idx] = can_wr;
        fifo_wr_en         = sel_valid && can_wr;
        fifo_din           = sel_data;
        if (fifo_wr_en && sel_last) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= GW'(N_SRC - 1);
      beat_cnt    <= '0;
      rec_count   <= '0;
      err_overlen <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && arb_go) begin
        grant_idx <= winner;
        beat_cnt  <= '0;
      end
      if (fifo_wr_en) begin
        if (beat_cnt != BEAT_SAT) beat_cnt <= beat_cnt + 1'b1;
        // Overlong records are flagged but still written in full.
        if (beat_cnt == BEAT_MAX && !sel_last) err_overlen <= 1'b1;
        if (sel_last) rec_count <= rec_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logger_fifo_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_logger_fifo_arb : directed scoreboard bench for logger_fifo_arb
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_logger_fifo_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  s_valid;
  logic [15:0] s_data;
  logic [1:0]  s_last;
  logic [1:0]  s_ready;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        fifo_full;
  logic        fifo_prog_full;
  logic        fifo_wr_rst_busy;
  logic        busy;
  logic [0:0]  grant_idx;
  logic [15:0] rec_count;
  logic        err_overlen;

  logger_fifo_arb #(.N_SRC(2), .MAX_REC_BYTES(56), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
    .fifo_wr_rst_busy(fifo_wr_rst_busy),
    .busy(busy), .grant_idx(grant_idx), .rec_count(rec_count),
    .err_overlen(err_overlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];

  int   checks = 0;
  int   errors = 0;
  int   rec_beats = 0;
  int   n_steps;
  logic bubble_pending = 1'b0;
  logic saw_wr = 1'b0;
  logic [1:0] last_ready = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_rec(input int src, input int len, input logic [7:0] base);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.src  = src;
      e.last = (k == len - 1);
      e.data = base + 8'(k);
      exp_q.push_back(e);
      if (src == 0) src_q0.push_back({e.last, e.data});
      else          src_q1.push_back({e.last, e.data});
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, return at the next falling edge.
  task automatic step();
    logic [1:0] beat;
    exp_t e;
    if (src_q0.size() > 0) begin
      s_valid[0] = 1'b1; s_data[7:0] = src_q0[0][7:0]; s_last[0] = src_q0[0][8];
    end else begin
      s_valid[0] = 1'b0; s_data[7:0] = 8'h00; s_last[0] = 1'b0;
    end
    if (src_q1.size() > 0) begin
      s_valid[1] = 1'b1; s_data[15:8] = src_q1[0][7:0]; s_last[1] = src_q1[0][8];
    end else begin
      s_valid[1] = 1'b0; s_data[15:8] = 8'h00; s_last[1] = 1'b0;
    end
    #1;
    beat       = s_valid & s_ready;
    saw_wr     = fifo_wr_en;
    last_ready = s_ready;
    if (bubble_pending) begin
      chk("bubble_wr_en", fifo_wr_en, 0);
      chk("bubble_busy", busy, 0);
      bubble_pending = 1'b0;
    end
    if (fifo_full) chk("no_wr_when_full", fifo_wr_en, 0);
    chk("wr_en_vs_handshake", fifo_wr_en, |beat);
    if (fifo_wr_en) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed write din=%0h expected no write", fifo_din);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("din", fifo_din, e.data);
        chk("wr_src", grant_idx, e.src);
        chk("ready_onehot", s_ready, 32'(1 << e.src));
        if (e.last) begin
          bubble_pending = 1'b1;
          rec_beats      = 0;
        end else begin
          rec_beats++;
        end
      end
    end
    if (beat[0]) void'(src_q0.pop_front());
    if (beat[1]) void'(src_q1.pop_front());
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int budget, output int n);
    n = 0;
    while ((src_q0.size() != 0 || src_q1.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL timeout: observed %0d cycles expected < %0d", n, budget);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_wr_en"}, fifo_wr_en, 0);
    chk({tag, "_din"}, fifo_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant_idx, 1);
    chk({tag, "_rec_count"}, rec_count, 0);
    chk({tag, "_err"}, err_overlen, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    rec_beats      = 0;
    bubble_pending = 1'b0;
    s_valid = '0; s_data = '0; s_last = '0;
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    s_valid = '0; s_data = '0; s_last = '0;
    fifo_full = 1'b0; fifo_prog_full = 1'b0; fifo_wr_rst_busy = 1'b0;
    @(negedge clk);
    do_reset();

    // Test 1: single 4-byte record from source 0
    push_rec(0, 4, 8'hA0);
    step();
    chk("t1_arb_cycle_wr", saw_wr, 0);
    chk("t1_busy_after_arb", busy, 1);
    chk("t1_grant", grant_idx, 0);
    step();
    chk("t1_first_beat", saw_wr, 1);
    run_until_empty(20, n);
    chk("t1_rec_count", rec_count, 1);
    chk("t1_busy_end", busy, 0);

    // Test 2: both sources, two 3-byte records each, strict alternation
    do_reset();
    push_rec(0, 3, 8'hB0);
    push_rec(1, 3, 8'hD0);
    push_rec(0, 3, 8'hC0);
    push_rec(1, 3, 8'hE0);
    run_until_empty(60, n);
    chk("t2_cycles", n, 16);
    chk("t2_rec_count", rec_count, 4);

    // Test 3: prog_full blocks arbitration
    fifo_prog_full = 1'b1;
    push_rec(1, 3, 8'h50);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_blocked_wr", saw_wr, 0);
      chk("t3_blocked_ready", last_ready, 0);
      chk("t3_blocked_busy", busy, 0);
    end
    fifo_prog_full = 1'b0;
    step();
    chk("t3_busy_after_release", busy, 1);
    chk("t3_grant", grant_idx, 1);
    step();
    chk("t3_first_beat", saw_wr, 1);
    run_until_empty(20, n);
    chk("t3_rec_count", rec_count, 5);

    // Test 4: fifo_full stalls mid-record; prog_full mid-record does not
    push_rec(0, 8, 8'h60);
    n = 0;
    while (rec_beats < 3 && n < 30) begin step(); n++; end
    fifo_full = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t4_full_wr", saw_wr, 0);
      chk("t4_full_ready", last_ready, 0);
    end
    fifo_full = 1'b0;
    fifo_prog_full = 1'b1;
    step();
    chk("t4_progfull_no_stall", saw_wr, 1);
    fifo_prog_full = 1'b0;
    run_until_empty(30, n);
    chk("t4_rec_count", rec_count, 6);

    // Test 5: 60-byte record overruns the 56-byte limit on beat 57
    push_rec(1, 60, 8'h00);
    n = 0;
    while (rec_beats < 56 && n < 100) begin step(); n++; end
    chk("t5_err_at_56", err_overlen, 0);
    while (rec_beats < 57 && n < 100) begin step(); n++; end
    chk("t5_err_at_57", err_overlen, 1);
    run_until_empty(30, n);
    chk("t5_rec_count", rec_count, 7);
    chk("t5_err_sticky", err_overlen, 1);

    // Test 6: reset during the 3rd byte of an 8-byte record
    push_rec(0, 8, 8'h80);
    n = 0;
    while (rec_beats < 2 && n < 30) begin step(); n++; end
    s_valid[0] = 1'b1;
    do_reset();
    push_rec(0, 3, 8'h90);
    push_rec(1, 3, 8'hF0);
    step();
    chk("t6_first_grant", grant_idx, 0);
    run_until_empty(30, n);
    chk("t6_rec_count", rec_count, 2);
    chk("t6_err_cleared", err_overlen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
